arb2_8: RTL and testbench

Two-channel 8-bit arbiter that sits directly upstream of the 8-bit 2:1 mux datapath and owns its select. It accepts bytes from two valid/ready producer channels, picks one per cycle, steers it through an internal `mux2_8` instance, and presents the chosen byte on a registered valid/ready output. It also counts completed output transfers.

---
 rtl/arb2_pkg.sv | 15 +
 rtl/mux2_8.sv | 17 +
 rtl/arb2_8.sv | 123 ++++++++++++
 tb/tb_arb2_8.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arb2_pkg.sv
// arb2_pkg: shared constants and types for the arb2_8 arbiter.
//   ARB2_W      - datapath width; fixed by the 8-bit mux2_8
//   ARB2_CW_DEF - default width of the transfer counter
//   last_t      - channel granted most recently (round-robin state)
package arb2_pkg;

  localparam int ARB2_W      = 8;
  localparam int ARB2_CW_DEF = 16;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_t;

endpackage

// File: rtl/mux2_8.sv
// mux2_8: 8-bit 2:1 combinational mux.
// Ports:
//   d0, d1 - data inputs
//   s      - select (0 -> d0, 1 -> d1)
//   y      - selected data
module mux2_8
  import arb2_pkg::*;
(
  input  logic [ARB2_W-1:0] d0,
  input  logic [ARB2_W-1:0] d1,
  input  logic              s,
  output logic [ARB2_W-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/arb2_8.sv
// arb2_8: two-channel 8-bit valid/ready arbiter driving a registered output slot.
// Picks at most one producer per cycle, steers its byte through mux2_8 and holds it
// in a one-entry output register. Counts completed output handshakes (wrapping).
// Build option: define ARB2_RR_EN for round-robin tie-break; otherwise channel 0
// always wins a tie and no last-grant state is built.
// Ports:
//   clk                 - clock, rising edge
//   reset               - synchronous, active-low reset
//   d0/d0_valid/d0_ready - channel 0 producer handshake
//   d1/d1_valid/d1_ready - channel 1 producer handshake
//   y/y_valid/y_ready   - registered output handshake
//   y_src               - channel that supplied the current y
//   xfer_cnt            - completed output handshakes, wrapping
module arb2_8
  import arb2_pkg::*;
#(
  parameter int W  = ARB2_W,
  parameter int CW = ARB2_CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  d0,
  input  logic          d0_valid,
  output logic          d0_ready,
  input  logic [W-1:0]  d1,
  input  logic          d1_valid,
  output logic          d1_ready,
  output logic [W-1:0]  y,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          y_src,
  output logic [CW-1:0] xfer_cnt
);

  if (W != ARB2_W) begin : g_w_chk
    $error("arb2_8: W must be 8 to match mux2_8");
  end

  logic [W-1:0]  r_y;
  logic          r_y_valid;
  logic          r_y_src;
  logic [CW-1:0] r_cnt;
  logic          r_s;       // last driven select, held while no channel is valid

  logic          w_ld;
  logic          w_gnt;
  logic          w_tie_gnt;
  logic          w_in_hs;
  logic          w_out_hs;
  logic [W-1:0]  w_mux_y;

`ifdef ARB2_RR_EN
  last_t r_last;

  // Tie goes to the channel not granted most recently.
  assign w_tie_gnt = (r_last == LAST0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= LAST1;
    end else if (w_in_hs) begin
      r_last <= w_gnt ? LAST1 : LAST0;
    end
  end
`else
  assign w_tie_gnt = 1'b0;
`endif

  assign w_ld = !r_y_valid || y_ready;

  always_comb begin
    w_gnt = r_s;
    if (d0_valid && d1_valid) begin
      w_gnt = w_tie_gnt;
    end else if (d0_valid) begin
      w_gnt = 1'b0;
    end else if (d1_valid) begin
      w_gnt = 1'b1;
    end
  end

  // Readies are masked during reset so no byte is accepted while state is clearing.
  assign d0_ready = reset && w_ld && !w_gnt && d0_valid;
  assign d1_ready = reset && w_ld &&  w_gnt && d1_valid;

  assign w_in_hs  = d0_ready || d1_ready;
  assign w_out_hs = r_y_valid && y_ready;

  mux2_8 u_mux (
    .d0 (d0),
    .d1 (d1),
    .s  (w_gnt),
    .y  (w_mux_y)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_src   <= 1'b0;
      r_cnt     <= '0;
      r_s       <= 1'b0;
    end else begin
      r_s <= w_gnt;
      if (w_in_hs) begin
        r_y       <= w_mux_y;
        r_y_src   <= w_gnt;
        r_y_valid <= 1'b1;
      end else if (y_ready) begin
        r_y_valid <= 1'b0;
      end
      if (w_out_hs) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign y        = r_y;
  assign y_valid  = r_y_valid;
  assign y_src    = r_y_src;
  assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_arb2_8.sv
// tb_arb2_8: directed self-checking bench for arb2_8 (counter built with CW=4).
module tb_arb2_8;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [7:0]    d0;
  logic          d0_valid;
  logic          d0_ready;
  logic [7:0]    d1;
  logic          d1_valid;
  logic          d1_ready;
  logic [7:0]    y;
  logic          y_valid;
  logic          y_ready;
  logic          y_src;
  logic [CW-1:0] xfer_cnt;

  int checks   = 0;
  int failures = 0;

  arb2_8 #(
    .W  (8),
    .CW (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .d0       (d0),
    .d0_valid (d0_valid),
    .d0_ready (d0_ready),
    .d1       (d1),
    .d1_valid (d1_valid),
    .d1_ready (d1_ready),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_src    (y_src),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [7:0] tie_exp [4];

  initial begin
`ifdef ARB2_RR_EN
    tie_exp[0] = 8'h11; tie_exp[1] = 8'h22; tie_exp[2] = 8'h11; tie_exp[3] = 8'h22;
`else
    tie_exp[0] = 8'h11; tie_exp[1] = 8'h11; tie_exp[2] = 8'h11; tie_exp[3] = 8'h11;
`endif

    // Reset with d0 pending: readies must stay low.
    reset = 1'b0; d0 = 8'hA5; d0_valid = 1'b1; d1 = 8'h00; d1_valid = 1'b0; y_ready = 1'b1;
    tick();
    tick();
    chk("rst_d0_ready", 32'(d0_ready), 32'd0);
    chk("rst_d1_ready", 32'(d1_ready), 32'd0);
    chk("rst_y",        32'(y),        32'd0);
    chk("rst_y_valid",  32'(y_valid),  32'd0);
    chk("rst_y_src",    32'(y_src),    32'd0);
    chk("rst_cnt",      32'(xfer_cnt), 32'd0);

    // Single-channel traffic.
    reset = 1'b1;
    #1;
    chk("single_d0_ready", 32'(d0_ready), 32'd1);
    chk("single_d1_ready", 32'(d1_ready), 32'd0);
    tick();
    chk("single_y",       32'(y),        32'hA5);
    chk("single_y_valid", 32'(y_valid),  32'd1);
    chk("single_y_src",   32'(y_src),    32'd0);
    chk("single_cnt0",    32'(xfer_cnt), 32'd0);
    d0_valid = 1'b0;
    tick();
    chk("single_cnt1",    32'(xfer_cnt), 32'd1);
    chk("single_drained", 32'(y_valid),  32'd0);

    // Fresh reset so the tie sequence starts from the reset grant history.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("tie_cnt_clr", 32'(xfer_cnt), 32'd0);
    d0 = 8'h11; d1 = 8'h22; d0_valid = 1'b1; d1_valid = 1'b1; y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("tie_y%0d", i),     32'(y),       32'(tie_exp[i]));
      chk($sformatf("tie_src%0d", i),   32'(y_src),   32'(tie_exp[i] == 8'h22));
      chk($sformatf("tie_valid%0d", i), 32'(y_valid), 32'd1);
    end
    chk("tie_cnt", 32'(xfer_cnt), 32'd3);

    // Load 3C, then stall the consumer with both channels valid.
    d0 = 8'h3C; d1_valid = 1'b0;
    tick();
    chk("bp_load_y", 32'(y),        32'h3C);
    chk("bp_cnt4",   32'(xfer_cnt), 32'd4);
    d0 = 8'h55; d1 = 8'h66; d1_valid = 1'b1; y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_d0_ready%0d", i), 32'(d0_ready), 32'd0);
      chk($sformatf("bp_d1_ready%0d", i), 32'(d1_ready), 32'd0);
      tick();
      chk($sformatf("bp_y%0d", i),       32'(y),        32'h3C);
      chk($sformatf("bp_valid%0d", i),   32'(y_valid),  32'd1);
      chk($sformatf("bp_src%0d", i),     32'(y_src),    32'd0);
      chk($sformatf("bp_cnt%0d", i),     32'(xfer_cnt), 32'd4);
    end

    // Channel 1 streams 00..07 with the consumer always ready.
    d0_valid = 1'b0; d1_valid = 1'b1; y_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d1 = 8'(k);
      #1;
      chk($sformatf("str_ready%0d", k), 32'(d1_ready), 32'd1);
      tick();
      chk($sformatf("str_y%0d", k),     32'(y),        32'(k));
      chk($sformatf("str_valid%0d", k), 32'(y_valid),  32'd1);
      chk($sformatf("str_src%0d", k),   32'(y_src),    32'd1);
      chk($sformatf("str_cnt%0d", k),   32'(xfer_cnt), 32'(5 + k));
    end
    d1_valid = 1'b0;
    tick();
    chk("str_end_valid", 32'(y_valid),  32'd0);
    chk("str_end_cnt",   32'(xfer_cnt), 32'd13);

    // Counter wrap on the 4-bit counter: 13 -> 14 -> 15 -> 0 -> 1.
    d0 = 8'h77; d0_valid = 1'b1;
    tick();
    chk("wrap_cnt13", 32'(xfer_cnt), 32'd13);
    tick();
    chk("wrap_cnt14", 32'(xfer_cnt), 32'd14);
    tick();
    chk("wrap_cnt15", 32'(xfer_cnt), 32'd15);
    tick();
    chk("wrap_cnt0",  32'(xfer_cnt), 32'd0);
    d0_valid = 1'b0;
    tick();
    chk("wrap_cnt1",  32'(xfer_cnt), 32'd1);

    // Reset while a byte is stalled in the output slot.
    d0 = 8'h99; d0_valid = 1'b1;
    tick();
    chk("mid_y", 32'(y), 32'h99);
    y_ready = 1'b0;
    tick();
    chk("mid_valid_held", 32'(y_valid),  32'd1);
    chk("mid_cnt_held",   32'(xfer_cnt), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_d0_ready", 32'(d0_ready), 32'd0);
    tick();
    chk("mid_rst_valid",    32'(y_valid),  32'd0);
    chk("mid_rst_cnt",      32'(xfer_cnt), 32'd0);
    chk("mid_rst_y",        32'(y),        32'd0);
    chk("mid_rst_d0_rdy2",  32'(d0_ready), 32'd0);
    chk("mid_rst_d1_rdy2",  32'(d1_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
